// File: rtl/lb_frame_bit_counter_pkg.sv
// Shared definitions for the UART frame bit counter and its helpers.
//   - Phase encodings reported on the phase output.
//   - Default legal data-width window and counter width.
//   - Counter FSM state encoding.
package lb_frame_bit_counter_pkg;

    localparam int DEF_MIN_DATA_BITS = 5;
    localparam int DEF_MAX_DATA_BITS = 9;
    localparam int DEF_CNT_W         = 4;

    typedef enum logic [1:0] {
        PH_START  = 2'd0,
        PH_DATA   = 2'd1,
        PH_PARITY = 2'd2,
        PH_STOP   = 2'd3
    } phase_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/lb_frame_bit_counter_if.sv
// Control/status bundle between the baud-tick side / shift-register FSM
// (master) and the frame bit counter (slave).
//   master drives : cs, load, inc, data_bits, parity_en, stop2
//   slave drives  : busy, bit_idx, phase, done, cfg_err
interface lb_frame_bit_counter_if
    import lb_frame_bit_counter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             cs;
    logic             load;
    logic             inc;
    logic [3:0]       data_bits;
    logic             parity_en;
    logic             stop2;
    logic             busy;
    logic [CNT_W-1:0] bit_idx;
    logic [1:0]       phase;
    logic             done;
    logic             cfg_err;

    modport master (
        output cs, load, inc, data_bits, parity_en, stop2,
        input  busy, bit_idx, phase, done, cfg_err
    );

    modport slave (
        input  cs, load, inc, data_bits, parity_en, stop2,
        output busy, bit_idx, phase, done, cfg_err
    );

endinterface

// File: rtl/lb_frame_len_calc.sv
// Combinational frame-length calculator, shared by the TX and RX sides.
//   data_bits : requested data width
//   parity_en : parity bit present
//   stop2     : two stop bits when high
//   total     : start + data + parity + stop bits
//   legal     : data_bits lies within [MIN_DATA_BITS, MAX_DATA_BITS]
module lb_frame_len_calc
    import lb_frame_bit_counter_pkg::*;
#(
    parameter int MIN_DATA_BITS = DEF_MIN_DATA_BITS,
    parameter int MAX_DATA_BITS = DEF_MAX_DATA_BITS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic [3:0]       data_bits,
    input  logic             parity_en,
    input  logic             stop2,
    output logic [CNT_W-1:0] total,
    output logic             legal
);

    localparam logic [3:0] MIN_L = 4'(MIN_DATA_BITS);
    localparam logic [3:0] MAX_L = 4'(MAX_DATA_BITS);

    // Every term is widened to CNT_W first so the sum never wraps for a
    // legal configuration; illegal widths produce a don't-care total.
    always_comb begin
        total = CNT_W'(1)
              + CNT_W'(data_bits)
              + CNT_W'(parity_en)
              + (stop2 ? CNT_W'(2) : CNT_W'(1));
        legal = (data_bits >= MIN_L) && (data_bits <= MAX_L);
    end

endmodule

// File: rtl/lb_frame_bit_counter.sv
// Parametrised UART frame bit counter.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of lb_frame_bit_counter_if
//           (cs/load/inc strobes and frame config in; busy, bit_idx,
//            phase, done and cfg_err out)
// A legal load latches the frame configuration and starts counting bit
// periods on inc; done pulses for one cycle after the last bit.
module lb_frame_bit_counter
    import lb_frame_bit_counter_pkg::*;
#(
    parameter int MIN_DATA_BITS = DEF_MIN_DATA_BITS,
    parameter int MAX_DATA_BITS = DEF_MAX_DATA_BITS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    lb_frame_bit_counter_if.slave bus
);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] bit_idx;
    logic [CNT_W-1:0] cfg_total;
    logic [3:0]       cfg_data_bits;
    logic             cfg_parity;
    logic             done_q;
    logic             cfg_err_q;
    logic [CNT_W-1:0] calc_total;
    logic             calc_legal;
    logic             load_go;
    logic             inc_go;
    logic             last_bit;
    phase_e           phase;

    lb_frame_len_calc #(
        .MIN_DATA_BITS (MIN_DATA_BITS),
        .MAX_DATA_BITS (MAX_DATA_BITS),
        .CNT_W         (CNT_W)
    ) u_len_calc (
        .data_bits (bus.data_bits),
        .parity_en (bus.parity_en),
        .stop2     (bus.stop2),
        .total     (calc_total),
        .legal     (calc_legal)
    );

    // Load wins over a simultaneous inc, so inc only qualifies without load.
    assign load_go  = bus.cs & bus.load;
    assign inc_go   = bus.cs & bus.inc & ~bus.load;
    assign last_bit = (bit_idx == (cfg_total - CNT_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An illegal load parks the counter in IDLE even if a frame was running.
    always_comb begin
        state_next = state;
        if (load_go) begin
            state_next = calc_legal ? ST_RUN : ST_IDLE;
        end else if ((state == ST_RUN) && inc_go && last_bit) begin
            state_next = ST_IDLE;
        end
    end

    // Counter, latched configuration and the registered done/cfg_err flags.
    // A rejected load leaves the previous configuration untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx       <= '0;
            cfg_total     <= '0;
            cfg_data_bits <= '0;
            cfg_parity    <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_go) begin
                bit_idx <= '0;
                if (calc_legal) begin
                    cfg_total     <= calc_total;
                    cfg_data_bits <= bus.data_bits;
                    cfg_parity    <= bus.parity_en;
                    cfg_err_q     <= 1'b0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end else if ((state == ST_RUN) && inc_go) begin
                if (last_bit) begin
                    bit_idx <= '0;
                    done_q  <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + CNT_W'(1);
                end
            end
        end
    end

    // Phase is decoded from the registered index against the latched config:
    // index 0 is the start bit, then the data bits, an optional parity bit,
    // and everything beyond is stop bits.
    always_comb begin
        phase = PH_START;
        if (state == ST_RUN) begin
            if (bit_idx == '0) begin
                phase = PH_START;
            end else if (bit_idx <= CNT_W'(cfg_data_bits)) begin
                phase = PH_DATA;
            end else if (cfg_parity &&
                         (bit_idx == (CNT_W'(cfg_data_bits) + CNT_W'(1)))) begin
                phase = PH_PARITY;
            end else begin
                phase = PH_STOP;
            end
        end
    end

    assign bus.busy    = (state == ST_RUN);
    assign bus.bit_idx = bit_idx;
    assign bus.phase   = phase;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_lb_frame_bit_counter.sv
// Scoreboard bench for lb_frame_bit_counter.
// The driver applies one stimulus per clock, advances a frame-level
// reference model (a list of per-bit phases built from the frame rules)
// and queues the expected outputs; a negedge monitor pops and compares.
module tb_lb_frame_bit_counter;
    import lb_frame_bit_counter_pkg::*;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic             busy;
        logic [CNT_W-1:0] idx;
        logic [1:0]       phase;
        logic             done;
        logic             cfg_err;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    lb_frame_bit_counter_if #(.CNT_W(CNT_W)) bus ();

    lb_frame_bit_counter #(
        .MIN_DATA_BITS (DEF_MIN_DATA_BITS),
        .MAX_DATA_BITS (DEF_MAX_DATA_BITS),
        .CNT_W         (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: the frame is a list of phases, one entry per bit.
    int m_seq[$];
    bit m_busy = 1'b0;
    int m_idx  = 0;
    bit m_err  = 1'b0;
    bit m_done = 1'b0;

    function automatic void build_frame(input int db, input bit par, input bit s2);
        m_seq.delete();
        m_seq.push_back(0);
        for (int k = 0; k < db; k++) m_seq.push_back(1);
        if (par) m_seq.push_back(2);
        m_seq.push_back(3);
        if (s2) m_seq.push_back(3);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.busy    = m_busy;
        o.idx     = CNT_W'(m_idx);
        o.phase   = m_busy ? 2'(m_seq[m_idx]) : 2'd0;
        o.done    = m_done;
        o.cfg_err = m_err;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy    = bus.busy;
        o.idx     = bus.bit_idx;
        o.phase   = bus.phase;
        o.done    = bus.done;
        o.cfg_err = bus.cfg_err;
        return o;
    endfunction

    task automatic check_output(input string name, input obs_t act, input obs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got busy=%0b idx=%0d phase=%0d done=%0b cfg_err=%0b, expected busy=%0b idx=%0d phase=%0d done=%0b cfg_err=%0b",
                     name, $time, act.busy, act.idx, act.phase, act.done, act.cfg_err,
                     exp.busy, exp.idx, exp.phase, exp.done, exp.cfg_err);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, queue the
    // outputs expected after that edge.
    task automatic apply_stimulus(input bit c, input bit l, input bit i,
                                  input int db, input bit par, input bit s2);
        bus.cs        = c;
        bus.load      = l;
        bus.inc       = i;
        bus.data_bits = 4'(db);
        bus.parity_en = par;
        bus.stop2     = s2;
        @(posedge clk);
        m_done = 1'b0;
        if (c && l) begin
            m_idx = 0;
            if (db >= DEF_MIN_DATA_BITS && db <= DEF_MAX_DATA_BITS) begin
                build_frame(db, par, s2);
                m_busy = 1'b1;
                m_err  = 1'b0;
            end else begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end
        end else if (c && i && m_busy) begin
            if (m_idx == m_seq.size() - 1) begin
                m_done = 1'b1;
                m_idx  = 0;
                m_busy = 1'b0;
            end else begin
                m_idx++;
            end
        end
        exp_q.push_back(model_obs());
        #1;
        bus.cs   = 1'b0;
        bus.load = 1'b0;
        bus.inc  = 1'b0;
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1, 0, 1, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (reset && exp_q.size() > 0) begin
            check_output("cycle", sample(), exp_q.pop_front());
        end
    end

    initial begin
        reset         = 1'b0;
        bus.cs        = 1'b0;
        bus.load      = 1'b0;
        bus.inc       = 1'b0;
        bus.data_bits = 4'd0;
        bus.parity_en = 1'b0;
        bus.stop2     = 1'b0;
        #12;
        check_output("reset_state", sample(), model_obs());
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] frame 8N1");
        apply_stimulus(1, 1, 0, 8, 0, 0);
        incs(10);
        apply_stimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] frame 9E2");
        apply_stimulus(1, 1, 0, 9, 1, 1);
        incs(13);
        apply_stimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] illegal configurations");
        apply_stimulus(1, 1, 0, 4, 0, 0);
        incs(3);
        apply_stimulus(1, 1, 0, 10, 1, 0);
        incs(2);
        apply_stimulus(1, 1, 0, 7, 0, 0);
        incs(9);

        $display("[TB] abort and restart");
        apply_stimulus(1, 1, 0, 8, 0, 0);
        incs(5);
        apply_stimulus(1, 1, 1, 8, 0, 0);
        incs(10);
        apply_stimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] chip-select gating");
        apply_stimulus(1, 1, 0, 8, 0, 0);
        incs(3);
        apply_stimulus(0, 1, 1, 4, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        incs(7);

        $display("[TB] asynchronous reset mid-frame");
        apply_stimulus(1, 1, 0, 8, 0, 0);
        incs(6);
        #2;
        reset = 1'b0;
        #1;
        m_busy = 1'b0;
        m_idx  = 0;
        m_err  = 1'b0;
        m_done = 1'b0;
        exp_q.delete();
        check_output("async_reset", sample(), model_obs());
        @(posedge clk);
        #1;
        reset = 1'b1;
        incs(3);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            apply_stimulus($urandom_range(0, 9) != 0,
                           $urandom_range(0, 11) == 0,
                           $urandom_range(0, 2) != 0,
                           int'($urandom_range(0, 15)),
                           $urandom_range(0, 1) == 1,
                           $urandom_range(0, 1) == 1);
        end

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
